instr_fetch_stage: RTL and testbench

//  - IF stage of the 5-stage pipelined CPU: owns the PC, drives the synchronous instruction memory

---
 rtl/instr_fetch_stage_pkg.sv | 30 +++
 rtl/instr_fetch_stage_pc_next_sel.sv | 40 ++++
 rtl/instr_fetch_stage.sv | 125 ++++++++++++
 tb/tb_instr_fetch_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_stage_pkg.sv
// Shared types and constants for the IF stage: defaults, PC increment,
// next-PC source encoding and the IF->ID payload.
package instr_fetch_stage_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INC        = 32'd4;

  typedef enum logic [2:0] {
    SRC_SEQ  = 3'd0,
    SRC_BR   = 3'd1,
    SRC_JR   = 3'd2,
    SRC_JMP  = 3'd3,
    SRC_HOLD = 3'd4
  } pc_src_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instr;
    logic            valid;
  } if_bus_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_stage_pc_next_sel.sv
// Next-PC priority mux: branch > jump-register > jump > stall hold > pc+4.
// Redirect targets are forced word-aligned; the increment wraps mod 2^32.
module instr_fetch_stage_pc_next_sel
  import instr_fetch_stage_pkg::*;
(
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_stall,
  input  logic            i_is_br,
  input  logic [XLEN-1:0] i_br_target,
  input  logic            i_is_jr,
  input  logic [XLEN-1:0] i_jr_target,
  input  logic            i_is_jmp,
  input  logic [XLEN-1:0] i_jmp_target,
  output logic [XLEN-1:0] o_pc_next_c,
  output pc_src_e         o_src_c
);

  logic [XLEN-1:0] w_pc_inc;

  assign w_pc_inc = i_pc + PC_INC;

  always_comb begin
    o_pc_next_c = w_pc_inc;
    o_src_c     = SRC_SEQ;
    if (i_is_br) begin
      o_pc_next_c = align_word(i_br_target);
      o_src_c     = SRC_BR;
    end else if (i_is_jr) begin
      o_pc_next_c = align_word(i_jr_target);
      o_src_c     = SRC_JR;
    end else if (i_is_jmp) begin
      o_pc_next_c = align_word(i_jmp_target);
      o_src_c     = SRC_JMP;
    end else if (i_stall) begin
      o_pc_next_c = i_pc;
      o_src_c     = SRC_HOLD;
    end
  end

endmodule

// File: rtl/instr_fetch_stage.sv
// IF stage: owns the PC, drives the synchronous imem read port and presents
// {pc, pc+4, instr, valid} to ID, with a skid register to ride out stalls.
module instr_fetch_stage
  import instr_fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_stall,
  input  logic            i_is_br,
  input  logic [XLEN-1:0] i_br_target,
  input  logic            i_is_jr,
  input  logic [XLEN-1:0] i_jr_target,
  input  logic            i_is_jmp,
  input  logic [XLEN-1:0] i_jmp_target,
  output logic [XLEN-1:0] o_imem_addr,
  output logic            o_imem_rd_en,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic [XLEN-1:0] o_if_pc,
  output logic [XLEN-1:0] o_if_pc_plus4,
  output logic [XLEN-1:0] o_if_instr,
  output logic            o_if_valid
);

  logic [XLEN-1:0] r_pc;
  logic            r_rsp_vld;
  logic [XLEN-1:0] r_rsp_pc;
  logic            r_held;
  logic [XLEN-1:0] r_hold_instr;

  logic [XLEN-1:0] w_pc_d;
  logic            w_rsp_vld_d;
  logic [XLEN-1:0] w_rsp_pc_d;
  logic            w_held_d;
  logic [XLEN-1:0] w_hold_instr_d;
  logic            w_rd_en;
  logic [XLEN-1:0] w_pc_next;
  pc_src_e         w_src;
  if_bus_t         w_if_bus;

  instr_fetch_stage_pc_next_sel u_pc_next_sel (
    .i_pc         (r_pc),
    .i_stall      (i_stall),
    .i_is_br      (i_is_br),
    .i_br_target  (i_br_target),
    .i_is_jr      (i_is_jr),
    .i_jr_target  (i_jr_target),
    .i_is_jmp     (i_is_jmp),
    .i_jmp_target (i_jmp_target),
    .o_pc_next_c  (w_pc_next),
    .o_src_c      (w_src)
  );

  // Next-state: redirects drop the in-flight read, stalls freeze and capture the word once.
  always_comb begin
    w_pc_d         = r_pc;
    w_rsp_vld_d    = r_rsp_vld;
    w_rsp_pc_d     = r_rsp_pc;
    w_held_d       = r_held;
    w_hold_instr_d = r_hold_instr;
    w_rd_en        = 1'b0;
    case (w_src)
      SRC_BR, SRC_JR, SRC_JMP: begin
        w_pc_d      = w_pc_next;
        w_rsp_vld_d = 1'b0;
        w_held_d    = 1'b0;
      end
      SRC_SEQ: begin
        w_rd_en     = 1'b1;
        w_pc_d      = w_pc_next;
        w_rsp_vld_d = 1'b1;
        w_rsp_pc_d  = r_pc;
        w_held_d    = 1'b0;
      end
      SRC_HOLD: begin
        if (r_rsp_vld && !r_held) begin
          w_hold_instr_d = i_imem_rdata;
          w_held_d       = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_rsp_vld    <= 1'b0;
      r_rsp_pc     <= '0;
      r_held       <= 1'b0;
      r_hold_instr <= NOP_INSTR;
    end else begin
      r_pc         <= w_pc_d;
      r_rsp_vld    <= w_rsp_vld_d;
      r_rsp_pc     <= w_rsp_pc_d;
      r_held       <= w_held_d;
      r_hold_instr <= w_hold_instr_d;
    end
  end

  // Read strobe is gated by reset so no fetch is issued while rst_n is low.
  assign o_imem_addr  = r_pc;
  assign o_imem_rd_en = w_rd_en & rst_n;

  always_comb begin
    w_if_bus.pc       = r_rsp_pc;
    w_if_bus.pc_plus4 = r_rsp_pc + PC_INC;
    w_if_bus.valid    = r_rsp_vld;
    if (!r_rsp_vld) begin
      w_if_bus.instr = NOP_INSTR;
    end else if (r_held) begin
      w_if_bus.instr = r_hold_instr;
    end else begin
      w_if_bus.instr = i_imem_rdata;
    end
  end

  assign o_if_pc       = w_if_bus.pc;
  assign o_if_pc_plus4 = w_if_bus.pc_plus4;
  assign o_if_instr    = w_if_bus.instr;
  assign o_if_valid    = w_if_bus.valid;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: startup, stall skid, redirect priority,
// PC wrap (second instance) and asynchronous reset mid-stall.
module tb_instr_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        is_br;
  logic [31:0] br_target;
  logic        is_jr;
  logic [31:0] jr_target;
  logic        is_jmp;
  logic [31:0] jmp_target;
  logic [31:0] imem_addr;
  logic        imem_rd_en;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instr;
  logic        if_valid;

  logic        rst2_n;
  logic        zero_b;
  logic [31:0] zero_w;
  logic [31:0] imem_addr2;
  logic        imem_rd_en2;
  logic [31:0] imem_rdata2;
  logic [31:0] if_pc2;
  logic [31:0] if_pc_plus4_2;
  logic [31:0] if_instr2;
  logic        if_valid2;

  int n_total;
  int n_bad;

  instr_fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_stall       (stall),
    .i_is_br       (is_br),
    .i_br_target   (br_target),
    .i_is_jr       (is_jr),
    .i_jr_target   (jr_target),
    .i_is_jmp      (is_jmp),
    .i_jmp_target  (jmp_target),
    .o_imem_addr   (imem_addr),
    .o_imem_rd_en  (imem_rd_en),
    .i_imem_rdata  (imem_rdata),
    .o_if_pc       (if_pc),
    .o_if_pc_plus4 (if_pc_plus4),
    .o_if_instr    (if_instr),
    .o_if_valid    (if_valid)
  );

  instr_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk           (clk),
    .rst_n         (rst2_n),
    .i_stall       (zero_b),
    .i_is_br       (zero_b),
    .i_br_target   (zero_w),
    .i_is_jr       (zero_b),
    .i_jr_target   (zero_w),
    .i_is_jmp      (zero_b),
    .i_jmp_target  (zero_w),
    .o_imem_addr   (imem_addr2),
    .o_imem_rd_en  (imem_rd_en2),
    .i_imem_rdata  (imem_rdata2),
    .o_if_pc       (if_pc2),
    .o_if_pc_plus4 (if_pc_plus4_2),
    .o_if_instr    (if_instr2),
    .o_if_valid    (if_valid2)
  );

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return 32'hA000_0000 | a;
  endfunction

  // Sync-read imem; returns junk when not strobed so the skid register is exercised.
  always @(posedge clk) begin
    imem_rdata  <= imem_rd_en  ? imem_word(imem_addr)  : 32'hDEAD_BEEF;
    imem_rdata2 <= imem_rd_en2 ? imem_word(imem_addr2) : 32'hDEAD_BEEF;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total    = 0;
    n_bad      = 0;
    rst_n      = 1'b0;
    rst2_n     = 1'b0;
    zero_b     = 1'b0;
    zero_w     = 32'h0;
    stall      = 1'b0;
    is_br      = 1'b0;
    is_jr      = 1'b0;
    is_jmp     = 1'b0;
    br_target  = 32'h0;
    jr_target  = 32'h0;
    jmp_target = 32'h0;

    // reset state
    step();
    step();
    check("rst_valid", 32'(if_valid), 32'h0);
    check("rst_instr", if_instr, 32'h0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_rd_en", 32'(imem_rd_en), 32'h0);

    // startup fetch stream
    rst_n  = 1'b1;
    rst2_n = 1'b1;
    #1;
    check("c1_addr", imem_addr, 32'h0);
    check("c1_rd_en", 32'(imem_rd_en), 32'h1);
    check("w_c1_addr", imem_addr2, 32'hFFFF_FFF8);
    step();
    check("c2_valid", 32'(if_valid), 32'h1);
    check("c2_pc", if_pc, 32'h0);
    check("c2_instr", if_instr, 32'hA000_0000);
    check("c2_pc4", if_pc_plus4, 32'h4);
    check("w_c2_pc", if_pc2, 32'hFFFF_FFF8);
    step();
    check("c3_pc", if_pc, 32'h4);
    check("c3_instr", if_instr, 32'hA000_0004);
    check("w_c3_pc", if_pc2, 32'hFFFF_FFFC);
    check("w_c3_pc4", if_pc_plus4_2, 32'h0);

    // stall three cycles while if_pc=8
    step();
    stall = 1'b1;
    #1;
    check("w_c4_pc", if_pc2, 32'h0);
    check("w_c4_instr", if_instr2, 32'hA000_0000);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      check("stl_pc", if_pc, 32'h8);
      check("stl_instr", if_instr, 32'hA000_0008);
      check("stl_valid", 32'(if_valid), 32'h1);
      check("stl_rd_en", 32'(imem_rd_en), 32'h0);
    end
    step();
    stall = 1'b0;
    #1;
    check("rel_pc", if_pc, 32'h8);
    check("rel_instr", if_instr, 32'hA000_0008);
    check("rel_addr", imem_addr, 32'hC);
    step();
    check("post_pc", if_pc, 32'hC);
    check("post_instr", if_instr, 32'hA000_000C);

    // branch redirect at if_pc=0x10
    step();
    is_br     = 1'b1;
    br_target = 32'h40;
    #1;
    check("br_cur_pc", if_pc, 32'h10);
    check("br_rd_en", 32'(imem_rd_en), 32'h0);
    step();
    is_br = 1'b0;
    #1;
    check("br_bub_valid", 32'(if_valid), 32'h0);
    check("br_bub_instr", if_instr, 32'h0);
    check("br_addr", imem_addr, 32'h40);
    step();
    check("br_tgt_pc", if_pc, 32'h40);
    check("br_tgt_instr", if_instr, 32'hA000_0040);
    check("br_tgt_valid", 32'(if_valid), 32'h1);

    // br beats jmp and stall
    is_br      = 1'b1;
    br_target  = 32'h80;
    is_jmp     = 1'b1;
    jmp_target = 32'h200;
    stall      = 1'b1;
    #1;
    check("pri1_rd_en", 32'(imem_rd_en), 32'h0);
    step();
    is_br  = 1'b0;
    is_jmp = 1'b0;
    stall  = 1'b0;
    #1;
    check("pri1_bub", 32'(if_valid), 32'h0);
    check("pri1_addr", imem_addr, 32'h80);
    step();
    check("pri1_pc", if_pc, 32'h80);

    // jr beats jmp
    is_jr      = 1'b1;
    jr_target  = 32'h300;
    is_jmp     = 1'b1;
    jmp_target = 32'h200;
    #1;
    check("pri2_rd_en", 32'(imem_rd_en), 32'h0);
    step();
    is_jr  = 1'b0;
    is_jmp = 1'b0;
    #1;
    check("pri2_bub", 32'(if_valid), 32'h0);
    check("pri2_addr", imem_addr, 32'h300);
    step();
    check("pri2_pc", if_pc, 32'h300);
    check("pri2_instr", if_instr, 32'hA000_0300);

    // async reset pulsed mid-stall
    stall = 1'b1;
    #1;
    step();
    check("hold_pc", if_pc, 32'h300);
    check("hold_instr", if_instr, 32'hA000_0300);
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(if_valid), 32'h0);
    check("arst_instr", if_instr, 32'h0);
    check("arst_addr", imem_addr, 32'h0);
    check("arst_pc", if_pc, 32'h0);
    check("arst_rd_en", 32'(imem_rd_en), 32'h0);
    rst_n = 1'b1;
    stall = 1'b0;
    #1;
    check("arel_addr", imem_addr, 32'h0);
    check("arel_rd_en", 32'(imem_rd_en), 32'h1);
    step();
    check("arel_pc", if_pc, 32'h0);
    check("arel_instr", if_instr, 32'hA000_0000);

    // misaligned jr target is forced to a word boundary
    is_jr     = 1'b1;
    jr_target = 32'h43;
    #1;
    step();
    is_jr = 1'b0;
    #1;
    check("aln_bub", 32'(if_valid), 32'h0);
    check("aln_addr", imem_addr, 32'h40);
    step();
    check("aln_pc", if_pc, 32'h40);
    check("aln_instr", if_instr, 32'hA000_0040);
    check("aln_pc4", if_pc_plus4, 32'h44);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
